// File: rtl/r_cpu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the R-type datapath.
// Decodes funct into ALU_OP, gates PC/IR/regfile writes, traps on illegal encodings.
module r_cpu_seq_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             run,
   input  logic [31:0]      Inst_code,
   input  logic             OF,
   input  logic             ZF,
   output logic             PC_Write,
   output logic             IR_Write,
   output logic             Reg_Write,
   output logic [2:0]       ALU_OP,
   output logic             busy,
   output logic             halted,
   output logic             ovf_sticky,
   output logic             zf_last,
   output logic [CNT_W-1:0] retired
);

   // state    | meaning
   // S_IDLE   | waiting for run
   // S_FETCH  | IR <= IMEM[PC], PC <= PC+4
   // S_DECODE | check opcode/funct, latch ALU_OP
   // S_EXEC   | ALU settles, capture OF/ZF
   // S_WB     | regfile write unless overflow
   // S_HALT   | illegal-instruction trap, left only by reset
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       alu_op_q, alu_op_d;
   logic             ovf_q, ovf_d;
   logic             zf_q, zf_d;
   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             legal;
   logic [2:0]       dec_op;
   logic             unused_fields;

   // rs/rt/rd/shamt do not affect sequencing
   assign unused_fields = ^Inst_code[25:6];

   always_comb begin
      legal  = 1'b1;
      dec_op = 3'b000;
      case (Inst_code[5:0])
         6'h24:   dec_op = 3'b000;
         6'h25:   dec_op = 3'b001;
         6'h26:   dec_op = 3'b010;
         6'h27:   dec_op = 3'b011;
         6'h20:   dec_op = 3'b100;
         6'h22:   dec_op = 3'b101;
         6'h2A:   dec_op = 3'b110;
         6'h04:   dec_op = 3'b111;
         default: legal  = 1'b0;
      endcase
      if (Inst_code[31:26] != 6'd0) legal = 1'b0;
   end

   always_comb begin
      state_d   = state_q;
      alu_op_d  = alu_op_q;
      ovf_d     = ovf_q;
      zf_d      = zf_q;
      sticky_d  = sticky_q;
      retired_d = retired_q;
      case (state_q)
         S_IDLE:   if (run) state_d = S_FETCH;
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            if (legal) begin
               alu_op_d = dec_op;
               state_d  = S_EXEC;
            end else begin
               state_d  = S_HALT;
            end
         end
         S_EXEC: begin
            ovf_d   = OF;
            zf_d    = ZF;
            state_d = S_WB;
         end
         S_WB: begin
            if (ovf_q) sticky_d  = 1'b1;
            else       retired_d = retired_q + CNT_W'(1);
            state_d = run ? S_FETCH : S_IDLE;
         end
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q   <= S_IDLE;
         alu_op_q  <= 3'b000;
         ovf_q     <= 1'b0;
         zf_q      <= 1'b0;
         sticky_q  <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         alu_op_q  <= alu_op_d;
         ovf_q     <= ovf_d;
         zf_q      <= zf_d;
         sticky_q  <= sticky_d;
         retired_q <= retired_d;
      end
   end

   // enables decode straight from the state register
   assign PC_Write   = (state_q == S_FETCH);
   assign IR_Write   = (state_q == S_FETCH);
   assign Reg_Write  = (state_q == S_WB) && !ovf_q;
   assign ALU_OP     = alu_op_q;
   assign busy       = (state_q != S_IDLE) && (state_q != S_HALT);
   assign halted     = (state_q == S_HALT);
   assign ovf_sticky = sticky_q;
   assign zf_last    = zf_q;
   assign retired    = retired_q;

endmodule

// File: tb/tb_r_cpu_seq_ctrl.sv
// Directed bench for r_cpu_seq_ctrl: stimulus pushes expected WB/trap outcomes,
// a monitor pops them as the DUT reaches writeback or halts.
module tb_r_cpu_seq_ctrl;

   localparam int CNT_W = 16;

   logic             CLK = 1'b0;
   logic             RST;
   logic             run;
   logic [31:0]      Inst_code;
   logic             OF;
   logic             ZF;
   logic             PC_Write;
   logic             IR_Write;
   logic             Reg_Write;
   logic [2:0]       ALU_OP;
   logic             busy;
   logic             halted;
   logic             ovf_sticky;
   logic             zf_last;
   logic [CNT_W-1:0] retired;

   r_cpu_seq_ctrl #(.CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST), .run(run), .Inst_code(Inst_code), .OF(OF), .ZF(ZF),
      .PC_Write(PC_Write), .IR_Write(IR_Write), .Reg_Write(Reg_Write),
      .ALU_OP(ALU_OP), .busy(busy), .halted(halted), .ovf_sticky(ovf_sticky),
      .zf_last(zf_last), .retired(retired)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      bit       trap;
      bit       wr;
      logic [2:0] op;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   exp_retired;
   bit   exp_sticky;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Phase counts cycles since the last IR_Write: 0 FETCH, 1 DECODE, 2 EXEC/HALT, 3 WB.
   initial begin : monitor
      int   phase;
      exp_t e;
      phase = 9;
      forever begin
         @(negedge CLK);
         if (IR_Write) phase = 0;
         else if (phase < 9) phase++;
         if ((phase == 3 && busy) || (phase == 2 && halted)) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_event", {30'd0, halted, busy}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("event_kind", {31'd0, halted}, {31'd0, e.trap});
               if (e.trap) begin
                  chk("trap_busy", {31'd0, busy}, 32'd0);
               end else begin
                  chk("wb_reg_write", {31'd0, Reg_Write}, {31'd0, e.wr});
                  chk("wb_alu_op", {29'd0, ALU_OP}, {29'd0, e.op});
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: time limit reached, expected finish");
      $fatal(1, "timeout");
   end

   task automatic push_wb(input bit wr, input logic [2:0] op);
      exp_t e;
      e.trap = 1'b0; e.wr = wr; e.op = op;
      exp_q.push_back(e);
   endtask

   task automatic push_trap();
      exp_t e;
      e.trap = 1'b1; e.wr = 1'b0; e.op = 3'b000;
      exp_q.push_back(e);
   endtask

   // One instruction from IDLE; run drops during DECODE so the controller returns to IDLE.
   task automatic exec_one(input logic [31:0] code, input logic of, input logic zf,
                           input logic [2:0] op, input bit legal);
      @(negedge CLK);
      Inst_code = code; OF = of; ZF = zf; run = 1'b1;
      if (legal) push_wb(!of, op);
      else       push_trap();
      @(negedge CLK);
      @(negedge CLK);
      run = 1'b0;
      repeat (3) @(negedge CLK);
      if (legal) begin
         if (of) exp_sticky = 1'b1;
         else    exp_retired++;
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b0; run = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      exp_retired = 0;
      exp_sticky  = 1'b0;
   endtask

   logic [31:0] sweep_code [8];
   initial begin
      sweep_code[0] = 32'h00221824; sweep_code[1] = 32'h00221825;
      sweep_code[2] = 32'h00221826; sweep_code[3] = 32'h00221827;
      sweep_code[4] = 32'h00221820; sweep_code[5] = 32'h00221822;
      sweep_code[6] = 32'h0022182A; sweep_code[7] = 32'h00221804;
   end

   initial begin : stim
      RST = 1'b0; run = 1'b1; Inst_code = 32'd0; OF = 1'b0; ZF = 1'b0;
      exp_retired = 0; exp_sticky = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b1; run = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         chk("idle_outputs",
             {7'd0, PC_Write, IR_Write, Reg_Write, ALU_OP, busy, halted, ovf_sticky, zf_last, retired},
             32'd0);
      end

      // back-to-back ADD
      @(posedge CLK); #1;
      Inst_code = 32'h00221820; OF = 1'b0; run = 1'b1;
      repeat (3) push_wb(1'b1, 3'b100);
      @(posedge CLK);
      for (int k = 1; k <= 12; k++) begin
         @(negedge CLK);
         chk("b2b_ir_write", {31'd0, IR_Write}, {31'd0, (k % 4) == 1});
         chk("b2b_reg_write", {31'd0, Reg_Write}, {31'd0, (k % 4) == 0});
         if (k == 10) run = 1'b0;
      end
      @(negedge CLK);
      exp_retired = 3;
      chk("b2b_retired", {16'd0, retired}, exp_retired);
      chk("b2b_idle_busy", {31'd0, busy}, 32'd0);

      // decode sweep
      for (int i = 0; i < 8; i++) begin
         exec_one(sweep_code[i], 1'b0, i[0], i[2:0], 1'b1);
         chk("sweep_alu_op", {29'd0, ALU_OP}, i);
         chk("sweep_zf_last", {31'd0, zf_last}, {31'd0, i[0]});
      end
      chk("sweep_retired", {16'd0, retired}, exp_retired);

      // shamt field ignored
      exec_one(32'h00221FE0, 1'b0, 1'b1, 3'b100, 1'b1);
      chk("shamt_retired", {16'd0, retired}, exp_retired);

      // overflow suppression then normal ADD
      exec_one(32'h00221822, 1'b1, 1'b0, 3'b101, 1'b1);
      chk("ovf_sticky_set", {31'd0, ovf_sticky}, 32'd1);
      chk("ovf_retired_hold", {16'd0, retired}, exp_retired);
      exec_one(32'h00221820, 1'b0, 1'b0, 3'b100, 1'b1);
      chk("ovf_sticky_keep", {31'd0, ovf_sticky}, {31'd0, exp_sticky});
      chk("post_ovf_retired", {16'd0, retired}, exp_retired);

      // illegal opcode (lw): trap, ALU_OP keeps the last ADD
      exec_one(32'h8C220000, 1'b0, 1'b0, 3'b000, 1'b0);
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         chk("halt_state", {29'd0, halted, busy, Reg_Write}, 32'b100);
      end
      chk("halt_alu_op", {29'd0, ALU_OP}, 32'd4);
      chk("halt_retired", {16'd0, retired}, exp_retired);
      do_reset();
      @(negedge CLK);
      chk("reset_from_halt",
          {7'd0, PC_Write, IR_Write, Reg_Write, ALU_OP, busy, halted, ovf_sticky, zf_last, retired},
          32'd0);

      // illegal funct (addu) with zero opcode
      exec_one(32'h00221820, 1'b0, 1'b0, 3'b100, 1'b1);
      exec_one(32'h00221821, 1'b0, 1'b0, 3'b000, 1'b0);
      chk("funct_trap_halted", {30'd0, halted, busy}, 32'b10);
      chk("funct_trap_alu_op", {29'd0, ALU_OP}, 32'd4);
      do_reset();

      // reset during EXEC
      @(negedge CLK);
      Inst_code = 32'h00221820; OF = 1'b0; run = 1'b1;
      @(negedge CLK);
      chk("mid_fetch", {31'd0, IR_Write}, 32'd1);
      @(negedge CLK);
      @(negedge CLK);
      chk("mid_exec_busy", {31'd0, busy}, 32'd1);
      RST = 1'b0; run = 1'b0;
      @(negedge CLK);
      chk("mid_reset_idle", {29'd0, busy, Reg_Write, IR_Write}, 32'd0);
      RST = 1'b1;
      repeat (4) begin
         @(negedge CLK);
         chk("mid_reset_quiet", {15'd0, Reg_Write, retired}, 32'd0);
      end

      repeat (3) @(negedge CLK);
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
